// File: rtl/l2_pkg.sv
// l2_pkg: shared channel FSM encoding and default geometry for the split L2
package l2_pkg;
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int SET_BITS_DEF = 5;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE_BACK, ALLOCATE} state_t;
endpackage

// File: rtl/l2_channel.sv
// l2_channel: one 2-way set-associative write-back, write-allocate cache channel
module l2_channel import l2_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SET_BITS = SET_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ready,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready
);
  localparam int SETS = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS;
  state_t r_state;
  logic [1:0][SETS-1:0] r_valid, r_dirty;
  logic [SETS-1:0] r_lru;
  logic [TAG_W-1:0] r_tag [2][SETS];
  logic [DATA_W-1:0] r_data [2][SETS];
  logic [SET_BITS-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic w_rd, w_wr, w_req, w_hit0, w_hit1, w_hit, w_hw, w_vic, w_vic_dirty;
  assign w_idx = i_addr[SET_BITS-1:0];
  assign w_tag = i_addr[ADDR_W-1:SET_BITS];
  assign w_rd = i_read;
  assign w_wr = i_write & ~i_read;
  assign w_req = i_read | i_write;
  assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit = w_hit0 | w_hit1;
  assign w_hw = ~w_hit0;
  // r_lru names the least recently used way, i.e. the next eviction candidate
  assign w_vic = !r_valid[0][w_idx] ? 1'b0 : !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
  assign w_vic_dirty = r_valid[w_vic][w_idx] & r_dirty[w_vic][w_idx];
  assign o_ready = r_state == ACCESS;
  assign o_rdata = (o_ready && w_rd) ? r_data[w_hw][w_idx] : '0;
  assign o_mem_write = r_state == WRITE_BACK;
  assign o_mem_read = r_state == ALLOCATE;
  assign o_mem_addr = o_mem_write ? {r_tag[w_vic][w_idx], w_idx} : o_mem_read ? i_addr : '0;
  assign o_mem_wdata = o_mem_write ? r_data[w_vic][w_idx] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_lru <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req) r_state <= w_hit ? ACCESS : w_vic_dirty ? WRITE_BACK : ALLOCATE;
        ACCESS: begin
          if (w_wr) r_dirty[w_hw][w_idx] <= 1'b1;
          r_lru[w_idx] <= ~w_hw;
          r_state <= IDLE;
        end
        WRITE_BACK: if (i_mem_ready) r_state <= ALLOCATE;
        ALLOCATE: if (i_mem_ready) begin
          r_valid[w_vic][w_idx] <= 1'b1;
          r_dirty[w_vic][w_idx] <= 1'b0;
          r_state <= ACCESS;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // payload arrays carry no reset; validity alone decides whether they mean anything
  always_ff @(posedge clk) begin
    if (r_state == ACCESS && w_wr) r_data[w_hw][w_idx] <= i_wdata;
    if (r_state == ALLOCATE && i_mem_ready) begin
      r_data[w_vic][w_idx] <= i_mem_rdata;
      r_tag[w_vic][w_idx] <= w_tag;
    end
  end
endmodule

// File: rtl/l2_cache_assoc.sv
// l2_cache_assoc: split instruction/data L2 built from two independent cache channels
module l2_cache_assoc import l2_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SET_BITS = SET_BITS_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              l1i_read,
  input  logic              l1i_write,
  input  logic [ADDR_W-1:0] l1i_addr,
  input  logic [DATA_W-1:0] l1i_wdata,
  output logic [DATA_W-1:0] l1i_rdata,
  output logic              l1i_ready,
  input  logic              l1d_read,
  input  logic              l1d_write,
  input  logic [ADDR_W-1:0] l1d_addr,
  input  logic [DATA_W-1:0] l1d_wdata,
  output logic [DATA_W-1:0] l1d_rdata,
  output logic              l1d_ready,
  output logic              memi_read,
  output logic              memi_write,
  output logic [ADDR_W-1:0] memi_addr,
  output logic [DATA_W-1:0] memi_wdata,
  input  logic [DATA_W-1:0] memi_rdata,
  input  logic              memi_ready,
  output logic              memd_read,
  output logic              memd_write,
  output logic [ADDR_W-1:0] memd_addr,
  output logic [DATA_W-1:0] memd_wdata,
  input  logic [DATA_W-1:0] memd_rdata,
  input  logic              memd_ready
);
  l2_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SET_BITS(SET_BITS)) u_icache (
    .clk(clk), .rst(proc_reset),
    .i_read(l1i_read), .i_write(l1i_write), .i_addr(l1i_addr), .i_wdata(l1i_wdata),
    .o_rdata(l1i_rdata), .o_ready(l1i_ready),
    .o_mem_read(memi_read), .o_mem_write(memi_write), .o_mem_addr(memi_addr),
    .o_mem_wdata(memi_wdata), .i_mem_rdata(memi_rdata), .i_mem_ready(memi_ready)
  );
  l2_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SET_BITS(SET_BITS)) u_dcache (
    .clk(clk), .rst(proc_reset),
    .i_read(l1d_read), .i_write(l1d_write), .i_addr(l1d_addr), .i_wdata(l1d_wdata),
    .o_rdata(l1d_rdata), .o_ready(l1d_ready),
    .o_mem_read(memd_read), .o_mem_write(memd_write), .o_mem_addr(memd_addr),
    .o_mem_wdata(memd_wdata), .i_mem_rdata(memd_rdata), .i_mem_ready(memd_ready)
  );
endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb_l2_cache_assoc: scoreboard bench with a recency-list cache model and backing memories
module tb_l2_cache_assoc;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int SB = 5;
  localparam int NS = 1 << SB;
  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef struct {logic [AW-SB-1:0] tag; data_t data; bit dirty;} ent_t;
  typedef struct {bit wb; addr_t a; data_t d;} mev_t;
  typedef struct {bit rd; data_t d; int lat; int cyc;} sbe_t;

  logic clk = 0;
  logic proc_reset = 0;
  logic l1_rd[2], l1_wr[2], l1_rdy[2], m_rd[2], m_wr[2], m_rdy[2];
  addr_t l1_addr[2], m_addr[2];
  data_t l1_wd[2], l1_rdata[2], m_wd[2], m_rdata[2];

  ent_t cq[2][NS][$];
  mev_t mexp[2][$];
  sbe_t sb[2][$];
  data_t rmem[logic [AW:0]];
  data_t dmem[logic [AW:0]];
  int mem_lat[2];
  int mem_txn[2];
  addr_t last_wb[2];
  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  l2_cache_assoc dut (
    .clk(clk), .proc_reset(proc_reset),
    .l1i_read(l1_rd[0]), .l1i_write(l1_wr[0]), .l1i_addr(l1_addr[0]), .l1i_wdata(l1_wd[0]),
    .l1i_rdata(l1_rdata[0]), .l1i_ready(l1_rdy[0]),
    .l1d_read(l1_rd[1]), .l1d_write(l1_wr[1]), .l1d_addr(l1_addr[1]), .l1d_wdata(l1_wd[1]),
    .l1d_rdata(l1_rdata[1]), .l1d_ready(l1_rdy[1]),
    .memi_read(m_rd[0]), .memi_write(m_wr[0]), .memi_addr(m_addr[0]), .memi_wdata(m_wd[0]),
    .memi_rdata(m_rdata[0]), .memi_ready(m_rdy[0]),
    .memd_read(m_rd[1]), .memd_write(m_wr[1]), .memd_addr(m_addr[1]), .memd_wdata(m_wd[1]),
    .memd_rdata(m_rdata[1]), .memd_ready(m_rdy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string nm, input data_t act, input data_t exp);
    vectors++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic data_t bk(input logic [AW:0] k);
    logic [31:0] x;
    x = 32'(k);
    return {x * 32'h9E3779B1, ~x, x ^ 32'hC0FFEE00, x + 32'h01234567};
  endfunction

  function automatic void clear_model();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < NS; s++) cq[c][s].delete();
      mexp[c].delete();
      sb[c].delete();
    end
  endfunction

  // each set is a recency list (front = most recent), at most two blocks
  task automatic model(input int ch, input bit w, input addr_t a, input data_t d,
                       output bit hit, output bit wb, output data_t ed);
    int s, pos;
    ent_t e, v;
    logic [AW:0] k;
    s = int'(a[SB-1:0]);
    pos = -1;
    hit = 0;
    wb = 0;
    for (int i = 0; i < cq[ch][s].size(); i++) if (cq[ch][s][i].tag == a[AW-1:SB]) pos = i;
    if (pos >= 0) begin
      e = cq[ch][s][pos];
      cq[ch][s].delete(pos);
      hit = 1;
    end else begin
      if (cq[ch][s].size() == 2) begin
        v = cq[ch][s].pop_back();
        if (v.dirty) begin
          wb = 1;
          rmem[{1'(ch), v.tag, a[SB-1:0]}] = v.data;
          mexp[ch].push_back('{1'b1, {v.tag, a[SB-1:0]}, v.data});
        end
      end
      k = {1'(ch), a};
      e.tag = a[AW-1:SB];
      e.data = rmem.exists(k) ? rmem[k] : bk(k);
      e.dirty = 0;
      mexp[ch].push_back('{1'b0, a, '0});
    end
    if (w) begin
      e.data = d;
      e.dirty = 1;
    end
    ed = e.data;
    cq[ch][s].push_front(e);
  endtask

  task automatic issue(input int ch, input bit w, input bit both, input addr_t a, input data_t d);
    bit hit, wb, seen;
    data_t ed;
    int lat;
    model(ch, w && !both, a, d, hit, wb, ed);
    lat = hit ? 1 : (!wb && mem_lat[ch] != 0) ? 1 + mem_lat[ch] : -1;
    sb[ch].push_back('{!w || both, ed, lat, cyc});
    l1_rd[ch] = !w || both;
    l1_wr[ch] = w;
    l1_addr[ch] = a;
    l1_wd[ch] = d;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = l1_rdy[ch];
    end
    chk(seen, "ready_timeout", data_t'(seen), data_t'(1));
    @(posedge clk);
    #1;
    l1_rd[ch] = 0;
    l1_wr[ch] = 0;
  endtask

  task automatic mem_proc(input int ch);
    int cnt;
    mev_t e;
    logic [AW:0] k;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (proc_reset || m_rdy[ch]) begin
        m_rdy[ch] = 0;
        cnt = 0;
      end else if (m_rd[ch] || m_wr[ch]) begin
        if (cnt == 0) cnt = mem_lat[ch] != 0 ? mem_lat[ch] : int'($urandom_range(1, 4));
        cnt--;
        if (cnt == 0) begin
          k = {1'(ch), m_addr[ch]};
          mem_txn[ch]++;
          chk(mexp[ch].size() != 0, "mem_unexpected", data_t'(m_addr[ch]), '0);
          if (mexp[ch].size() != 0) begin
            e = mexp[ch].pop_front();
            chk(m_wr[ch] == e.wb, "mem_kind_wb", data_t'(m_wr[ch]), data_t'(e.wb));
            chk(m_addr[ch] == e.a, "mem_addr", data_t'(m_addr[ch]), data_t'(e.a));
            if (e.wb) chk(m_wd[ch] == e.d, "wb_data", m_wd[ch], e.d);
          end
          if (m_wr[ch]) begin
            dmem[k] = m_wd[ch];
            last_wb[ch] = m_addr[ch];
          end else m_rdata[ch] = dmem.exists(k) ? dmem[k] : bk(k);
          m_rdy[ch] = 1;
        end
      end
    end
  endtask

  initial begin
    sbe_t e;
    int lat;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        chk(!(m_rd[c] && m_wr[c]), "mem_rd_wr_both", data_t'({m_rd[c], m_wr[c]}), '0);
        if (proc_reset)
          chk((l1_rdata[c] | m_wd[c] | data_t'(m_addr[c]) | data_t'({l1_rdy[c], m_rd[c], m_wr[c]})) == '0,
              "reset_outputs_zero", l1_rdata[c] | m_wd[c], '0);
        if (!l1_rdy[c]) chk(l1_rdata[c] == '0, "rdata_not_ready", l1_rdata[c], '0);
        else begin
          chk(sb[c].size() != 0, "unexpected_ready", data_t'(c), '0);
          if (sb[c].size() != 0) begin
            e = sb[c].pop_front();
            lat = cyc - e.cyc;
            if (e.rd) chk(l1_rdata[c] == e.d, "read_data", l1_rdata[c], e.d);
            if (e.lat > 0) chk(lat == e.lat, "latency", data_t'(lat), data_t'(e.lat));
            else chk(lat >= 2, "miss_latency", data_t'(lat), data_t'(2));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 proc_reset = 1;
    clear_model();
    for (int c = 0; c < 2; c++) begin
      l1_rd[c] = 0;
      l1_wr[c] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    #2 proc_reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int ch, input int n);
    addr_t a;
    data_t d;
    int op;
    for (int i = 0; i < n; i++) begin
      a = {23'($urandom_range(0, 5)), 5'($urandom_range(0, 3))};
      op = int'($urandom_range(0, 3));
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(ch, op >= 2, op == 3, a, d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    data_t a5;
    a5 = {16{8'hA5}};
    for (int c = 0; c < 2; c++) begin
      l1_rd[c] = 0; l1_wr[c] = 0; l1_addr[c] = '0; l1_wd[c] = '0;
      m_rdy[c] = 0; m_rdata[c] = '0; mem_lat[c] = 0; mem_txn[c] = 0; last_wb[c] = '0;
    end
    fork
      mem_proc(0);
      mem_proc(1);
    join_none
    do_reset();
    mem_lat[0] = 3;
    mem_lat[1] = 2;
    issue(0, 0, 0, 28'h0000020, '0);
    t0 = mem_txn[0];
    issue(0, 0, 0, 28'h0000020, '0);
    chk(mem_txn[0] == t0, "hit_no_memi", data_t'(mem_txn[0] - t0), '0);
    issue(1, 1, 0, 28'h0000001, a5);
    t0 = mem_txn[1];
    issue(1, 0, 0, 28'h0000001, '0);
    chk(mem_txn[1] == t0, "dhit_no_memd", data_t'(mem_txn[1] - t0), '0);
    fork
      issue(0, 0, 0, 28'h0000444, '0);
      issue(1, 0, 0, 28'h0000001, '0);
    join
    do_reset();
    issue(1, 1, 0, 28'h0000021, {4{32'h11111111}});
    issue(1, 1, 0, 28'h0000041, {4{32'h22222222}});
    t0 = mem_txn[1];
    issue(1, 0, 0, 28'h0000061, '0);
    chk(last_wb[1] == 28'h0000021, "conflict_wb_addr", data_t'(last_wb[1]), data_t'(28'h21));
    chk(mem_txn[1] - t0 == 2, "conflict_wb_alloc", data_t'(mem_txn[1] - t0), data_t'(2));
    issue(1, 0, 0, 28'h0000021, '0);
    do_reset();
    l1_rd[0] = 1;
    l1_addr[0] = 28'h0000345;
    @(negedge clk);
    @(negedge clk);
    chk(m_rd[0] == 1'b1, "alloc_active", data_t'(m_rd[0]), data_t'(1));
    chk(m_addr[0] == 28'h0000345, "alloc_addr", data_t'(m_addr[0]), data_t'(28'h345));
    @(posedge clk);
    #2 proc_reset = 1;
    clear_model();
    #1;
    chk(m_rd[0] == 1'b0, "alloc_abort", data_t'(m_rd[0]), '0);
    @(posedge clk);
    #1 l1_rd[0] = 0;
    @(posedge clk);
    #2 proc_reset = 0;
    @(posedge clk);
    #1;
    t0 = mem_txn[0];
    issue(0, 0, 0, 28'h0000345, '0);
    chk(mem_txn[0] - t0 == 1, "realloc_after_reset", data_t'(mem_txn[0] - t0), data_t'(1));
    mem_lat[0] = 0;
    mem_lat[1] = 0;
    fork
      rand_run(0, 300);
      rand_run(1, 300);
    join
    repeat (5) @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      chk(sb[c].size() == 0, "scoreboard_drained", data_t'(sb[c].size()), '0);
      chk(mexp[c].size() == 0, "mem_events_drained", data_t'(mexp[c].size()), '0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/l2_cache_assoc.md
L2_CACHE_ASSOC -- requirements
Module: l2_cache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 28: L1/memory block-address width.
REQ-002 SHALL have parameter DATA_W, default 128: block data width.
REQ-003 SHALL have parameter SET_BITS, default 5: per-channel index width, giving 2^SET_BITS sets per channel; tag width = ADDR_W-SET_BITS.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk first, then proc_reset.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 proc_reset  input  1  asynchronous active-high reset.
REQ-007 l1i_read, l1i_write  input  1 each  instruction-side request, held until l1i_ready.
REQ-008 l1i_addr  input  ADDR_W  block address; l1i_wdata  input  DATA_W  write block.
REQ-009 l1i_rdata  output  DATA_W  read block; l1i_ready  output  1  one-cycle completion pulse.
REQ-010 l1d_read, l1d_write, l1d_addr, l1d_wdata, l1d_rdata, l1d_ready SHALL mirror REQ-007..009 for the data side.
REQ-011 memi_read, memi_write  output  1 each; memi_addr  output  ADDR_W; memi_wdata  output  DATA_W; memi_rdata  input  DATA_W; memi_ready  input  1.
REQ-012 memd_* SHALL mirror REQ-011 for the data side.

Function
REQ-013 Each channel SHALL be an independent 2-way set-associative, write-back, write-allocate cache; I and D never share sets or stall each other.
REQ-014 index = addr[SET_BITS-1:0]; tag = addr[ADDR_W-1:SET_BITS]; each way SHALL hold valid, dirty, tag, data; each set SHALL hold one LRU bit.
REQ-015 Channel FSM states SHALL be IDLE, ACCESS, WRITE_BACK, ALLOCATE.
REQ-016 IDLE: request with hit -> ACCESS; miss with victim clean or invalid -> ALLOCATE; miss with victim valid and dirty -> WRITE_BACK; no request -> IDLE.
REQ-017 Victim SHALL be the first invalid way (way 0 before way 1), else the way indicated by the LRU bit.
REQ-018 ACCESS: ready=1 for exactly one cycle; read drives rdata = hit-way data in the same cycle; write replaces hit-way data and sets dirty; LRU points to the other way; next state IDLE.
REQ-019 WRITE_BACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data, held until mem_ready; on mem_ready -> ALLOCATE.
REQ-020 ALLOCATE: mem_read=1, mem_addr=request address, held until mem_ready; on mem_ready the victim way SHALL load mem_rdata with valid=1, dirty=0, new tag -> ACCESS.
REQ-021 Hit latency SHALL be 2 cycles from request to ready; clean miss SHALL be 2 cycles plus memory latency.
REQ-022 mem_read and mem_write SHALL never be high together; both SHALL be 0 in IDLE and ACCESS.
REQ-023 Read and write high together SHALL be treated as a read.
REQ-024 rdata SHALL be 0 whenever ready=0.
REQ-025 Request address and wdata SHALL be sampled on the cycle of use; L1 holds them stable until ready.

Reset
REQ-026 proc_reset SHALL immediately force both FSMs to IDLE and clear all valid, dirty and LRU bits.
REQ-027 During reset all outputs SHALL be 0, including while a memory transfer is in flight, which is abandoned.
REQ-028 Data and tag arrays need not be reset.

Structure
REQ-029 FSM state encodings and default parameter values SHALL live in a shared package, l2_pkg.
REQ-030 One channel (arrays plus FSM) SHALL be a sub-module, l2_channel, instantiated twice by l2_cache_assoc.

Verification
REQ-031 Cold read of I addr 0x0000020 with 3-cycle memory: memi_read with addr 0x0000020, fill, l1i_ready once with the filled block; repeat read returns the same data in 2 cycles with no memi activity.
REQ-032 D write 0xA5..A5 to 0x0000001, then read 0x0000001 (hit): rdata = 0xA5..A5, no memd traffic.
REQ-033 Dirty 3-way conflict in D set 1 (tags 1, 2, 3, writes to tags 1 and 2): third miss writes back the LRU block (tag 1) at its address, then allocates tag 3.
REQ-034 Simultaneous I miss and D hit: l1d_ready asserts 2 cycles after its request, unaffected by the pending memi_read.
REQ-035 proc_reset pulse during ALLOCATE: memi_read drops at once; a re-read of the same address misses and reallocates.
